prbs_checker: RTL and testbench

Serial PRBS checker, the receive end of the team's LFSR pattern generator. Consumes one bit per enabled cycle, self-synchronises its internal LFSR to the incoming stream, then flags and counts every bit that departs from the predicted sequence. Sits at the far end of a link or loopback under test; exposes lock status and a saturating error count to the control/status logic.

---
 rtl/prbs_checker.sv | 151 +++++++++++++++
 tb/tb_prbs_checker.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// Serial PRBS checker for the x^WIDTH + x^(WIDTH-1) + 1 pattern generator.
// Self-synchronises to the received stream, then flags and counts bit errors while locked.
module prbs_checker #(
  parameter int WIDTH     = 7,
  parameter int SYNC_LEN  = 16,
  parameter int LOSS_LEN  = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 bit_in,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(SYNC_LEN + 1);
  localparam int LOSS_W  = $clog2(LOSS_LEN + 1);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(SYNC_LEN - 1);
  localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_LEN - 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     r_q, r_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [LOSS_W-1:0]    loss_q, loss_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pulse_q, pulse_d;
  logic                 locked_q, locked_d;

  logic             pred;
  logic             mismatch;
  logic [WIDTH-1:0] shifted_in;

  assign pred       = r_q[WIDTH-1] ^ r_q[WIDTH-2];
  assign mismatch   = bit_in ^ pred;
  assign shifted_in = {r_q[WIDTH-2:0], bit_in};

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    fill_d  = fill_q;
    match_d = match_q;
    loss_d  = loss_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;

    if (en) begin
      case (state_q)
        ST_HUNT: begin
          r_d = shifted_in;
          if (fill_q == FILL_LAST) begin
            fill_d = '0;
            // An all-zero register is the LFSR lock-up state; refill instead of verifying it.
            if (|shifted_in) begin
              state_d = ST_VERIFY;
              match_d = '0;
            end
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end

        ST_VERIFY: begin
          r_d = shifted_in;
          if (!mismatch) begin
            if (match_q == MATCH_LAST) begin
              state_d = ST_LOCKED;
              match_d = '0;
              loss_d  = '0;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            state_d = ST_HUNT;
            fill_d  = '0;
          end
        end

        ST_LOCKED: begin
          // Free-running reference: received errors never enter the register.
          r_d = {r_q[WIDTH-2:0], pred};
          if (mismatch) begin
            pulse_d = 1'b1;
            if (cnt_q != {CNT_WIDTH{1'b1}}) begin
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end
            if (loss_q == LOSS_LAST) begin
              state_d = ST_HUNT;
              fill_d  = '0;
              loss_d  = '0;
            end else begin
              loss_d = loss_q + LOSS_W'(1);
            end
          end else begin
            loss_d = '0;
          end
        end

        default: begin
          state_d = ST_HUNT;
          fill_d  = '0;
        end
      endcase

      if (clear_cnt) begin
        cnt_d = '0;
      end
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_HUNT;
      r_q      <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      loss_q   <= '0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      loss_q   <= loss_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      locked_q <= locked_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = pulse_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, errors, loss/relock, en gaps, lock-up, counter rules, reset.
// A second instance with a 2-bit counter shares all stimulus for the saturation checks.
module tb_prbs_checker;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        bit_in;
  logic        clear_cnt;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic        locked2;
  logic        err_pulse2;
  logic [1:0]  err_count2;

  int   n_pass;
  int   n_total;
  bit   gaps_on;
  logic [6:0] gen;

  prbs_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bit_in    (bit_in),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  prbs_checker #(.CNT_WIDTH(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bit_in    (bit_in),
    .clear_cnt (clear_cnt),
    .locked    (locked2),
    .err_pulse (err_pulse2),
    .err_count (err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_gen(output logic b);
    b   = gen[6] ^ gen[5];
    gen = {gen[5:0], b};
  endtask

  // One accepted bit, optionally preceded by random idle (en=0) cycles.
  task automatic send(input logic b, input logic clr);
    if (gaps_on) begin
      for (int k = 0; k < 6 && $urandom_range(0, 1) == 1; k++) begin
        en        = 1'b0;
        bit_in    = 1'($urandom_range(0, 1));
        clear_cnt = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    en        = 1'b1;
    bit_in    = b;
    clear_cnt = clr;
    @(posedge clk);
    #1;
    en        = 1'b0;
    clear_cnt = 1'b0;
  endtask

  task automatic run_clean(input int nbits, input int inv_at, output int lock_at,
                           output int pulses, output int drops);
    logic b;
    lock_at = -1;
    pulses  = 0;
    drops   = 0;
    for (int i = 1; i <= nbits; i++) begin
      next_gen(b);
      if (i == inv_at) b = ~b;
      send(b, 1'b0);
      if (locked && lock_at < 0) lock_at = i;
      if (!locked && lock_at >= 0) drops++;
      if (err_pulse) pulses++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    en        = 1'b0;
    bit_in    = 1'b0;
    clear_cnt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    en        = 1'b0;
    bit_in    = 1'b0;
    clear_cnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else n_pass++;
    n_total++;
    if (err_pulse !== 1'b0) $display("FAIL reset_err_pulse: got %b want 0", err_pulse); else n_pass++;
    n_total++;
    if (err_count !== 16'd0) $display("FAIL reset_err_count: got %0d want 0", err_count); else n_pass++;
    n_total++;
    if (err_count2 !== 2'd0 || locked2 !== 1'b0) $display("FAIL reset_dut2: count %0d locked %b want 0/0", err_count2, locked2); else n_pass++;
    $display("reset: locked=%b err_pulse=%b err_count=%0d", locked, err_pulse, err_count);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clean_lock();
    int lock_at, pulses, drops;
    gen = 7'b0000001;
    run_clean(500, 0, lock_at, pulses, drops);
    n_total++;
    if (lock_at !== 23) $display("FAIL clean_lock_bit: got %0d want 23", lock_at); else n_pass++;
    n_total++;
    if (drops !== 0 || locked !== 1'b1) $display("FAIL clean_lock_stays: drops %0d locked %b want 0/1", drops, locked); else n_pass++;
    n_total++;
    if (pulses !== 0) $display("FAIL clean_err_pulse: got %0d pulses want 0", pulses); else n_pass++;
    n_total++;
    if (err_count !== 16'd0) $display("FAIL clean_err_count: got %0d want 0", err_count); else n_pass++;
    $display("clean_lock: lock_bit=%0d drops=%0d pulses=%0d err_count=%0d", lock_at, drops, pulses, err_count);
  endtask

  task automatic test_single_error();
    logic b;
    int lock_at, pulses, drops;
    next_gen(b);
    send(~b, 1'b0);
    n_total++;
    if (err_pulse !== 1'b1) $display("FAIL single_pulse: got %b want 1", err_pulse); else n_pass++;
    n_total++;
    if (err_count !== 16'd1) $display("FAIL single_count: got %0d want 1", err_count); else n_pass++;
    n_total++;
    if (locked !== 1'b1) $display("FAIL single_locked: got %b want 1", locked); else n_pass++;
    next_gen(b);
    send(b, 1'b0);
    n_total++;
    if (err_pulse !== 1'b0) $display("FAIL single_pulse_width: got %b want 0", err_pulse); else n_pass++;
    run_clean(100, 0, lock_at, pulses, drops);
    n_total++;
    if (err_count !== 16'd1 || pulses !== 0 || drops !== 0)
      $display("FAIL single_after_clean: count %0d pulses %0d drops %0d want 1/0/0", err_count, pulses, drops);
    else n_pass++;
    $display("single_error: err_count=%0d locked=%b", err_count, locked);
  endtask

  task automatic test_loss_relock(input bit with_gaps);
    logic b;
    int lock_at, pulses, drops;
    gaps_on = with_gaps;
    next_gen(b);
    send(b, 1'b1);
    n_total++;
    if (err_count !== 16'd0 || locked !== 1'b1) $display("FAIL loss%0d_precond: count %0d locked %b want 0/1", with_gaps, err_count, locked); else n_pass++;
    for (int e = 1; e <= 4; e++) begin
      next_gen(b);
      send(~b, 1'b0);
      n_total++;
      if (err_pulse !== 1'b1) $display("FAIL loss%0d_pulse_%0d: got %b want 1", with_gaps, e, err_pulse); else n_pass++;
      n_total++;
      if (locked !== (e < 4)) $display("FAIL loss%0d_locked_%0d: got %b want %b", with_gaps, e, locked, e < 4); else n_pass++;
    end
    n_total++;
    if (err_count !== 16'd4) $display("FAIL loss%0d_count: got %0d want 4", with_gaps, err_count); else n_pass++;
    if (with_gaps) begin
      en = 1'b0;
      @(posedge clk);
      #1;
      n_total++;
      if (err_pulse !== 1'b0 || err_count !== 16'd4) $display("FAIL gap_hold: pulse %b count %0d want 0/4", err_pulse, err_count); else n_pass++;
    end
    run_clean(40, 0, lock_at, pulses, drops);
    n_total++;
    if (lock_at !== 23) $display("FAIL loss%0d_relock_bit: got %0d want 23", with_gaps, lock_at); else n_pass++;
    n_total++;
    if (err_count !== 16'd4 || pulses !== 0) $display("FAIL loss%0d_relock_count: count %0d pulses %0d want 4/0", with_gaps, err_count, pulses); else n_pass++;
    $display("loss_relock gaps=%0d: err_count=%0d relock_bit=%0d", with_gaps, err_count, lock_at);
    gaps_on = 1'b0;
  endtask

  task automatic test_lockup_verify_fail();
    int lock_at, pulses, drops;
    int lock_seen, cnt_seen;
    do_reset();
    lock_seen = 0;
    cnt_seen  = 0;
    for (int i = 0; i < 100; i++) begin
      send(1'b0, 1'b0);
      if (locked) lock_seen++;
      if (err_count != 16'd0) cnt_seen++;
    end
    n_total++;
    if (lock_seen !== 0 || cnt_seen !== 0) $display("FAIL lockup_zeros: locked %0d cycles, count nonzero %0d cycles, want 0/0", lock_seen, cnt_seen); else n_pass++;
    // Fresh start so the inverted 10th bit lands in VERIFY.
    do_reset();
    gen = 7'b0000001;
    run_clean(60, 10, lock_at, pulses, drops);
    n_total++;
    if (lock_at !== 33) $display("FAIL verify_fail_lock_bit: got %0d want 33", lock_at); else n_pass++;
    n_total++;
    if (err_count !== 16'd0 || pulses !== 0) $display("FAIL verify_fail_count: count %0d pulses %0d want 0/0", err_count, pulses); else n_pass++;
    $display("lockup_verify: lock_bit=%0d err_count=%0d", lock_at, err_count);
  endtask

  task automatic test_counter_rules();
    logic b;
    int lock_at, pulses, drops;
    do_reset();
    gen = 7'b0000001;
    run_clean(23, 0, lock_at, pulses, drops);
    n_total++;
    if (locked2 !== 1'b1) $display("FAIL cnt_dut2_locked: got %b want 1", locked2); else n_pass++;
    for (int e = 0; e < 5; e++) begin
      next_gen(b);
      send(~b, 1'b0);
      run_clean(3, 0, lock_at, pulses, drops);
    end
    n_total++;
    if (err_count2 !== 2'd3) $display("FAIL cnt_saturate: got %0d want 3", err_count2); else n_pass++;
    n_total++;
    if (err_count !== 16'd5 || locked2 !== 1'b1) $display("FAIL cnt_wide: count %0d locked2 %b want 5/1", err_count, locked2); else n_pass++;
    next_gen(b);
    send(~b, 1'b1);
    n_total++;
    if (err_count2 !== 2'd0 || err_count !== 16'd0) $display("FAIL cnt_clear_wins: got %0d/%0d want 0/0", err_count2, err_count); else n_pass++;
    n_total++;
    if (err_pulse2 !== 1'b1) $display("FAIL cnt_clear_pulse: got %b want 1", err_pulse2); else n_pass++;
    $display("counter_rules: sat_count=%0d after_clear=%0d", 3, err_count2);
  endtask

  task automatic test_reset_mid_lock();
    logic b;
    int lock_at, pulses, drops;
    next_gen(b);
    send(~b, 1'b0);
    run_clean(2, 0, lock_at, pulses, drops);
    next_gen(b);
    send(~b, 1'b0);
    n_total++;
    if (err_count !== 16'd2 || err_pulse !== 1'b1 || locked !== 1'b1)
      $display("FAIL midreset_precond: count %0d pulse %b locked %b want 2/1/1", err_count, err_pulse, locked);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'd0)
      $display("FAIL midreset_async: locked %b pulse %b count %0d want 0/0/0", locked, err_pulse, err_count);
    else n_pass++;
    #2;
    rst_n = 1'b1;
    run_clean(40, 0, lock_at, pulses, drops);
    n_total++;
    if (lock_at !== 23) $display("FAIL midreset_relock_bit: got %0d want 23", lock_at); else n_pass++;
    $display("reset_mid_lock: relock_bit=%0d err_count=%0d", lock_at, err_count);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    gaps_on = 1'b0;
    gen     = 7'b0000001;
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_relock(1'b0);
    test_loss_relock(1'b1);
    test_lockup_verify_fail();
    test_counter_rules();
    test_reset_mid_lock();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
